// File: rtl/cordic_pkg.sv
// Shared types and defaults for the CORDIC custom-instruction front end.
// Holds the controller state encoding and the default widths/values.
package cordic_pkg;

  localparam int unsigned CORDIC_DATA_W = 32;
  localparam logic [31:0] CORDIC_ERR_VALUE = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } cordic_state_e;

endpackage

// File: rtl/cordic_ci_watchdog.sv
// WAIT-state watchdog: counts enabled WAIT cycles and flags expiry on the
// TIMEOUT-th one. Ports: clk, rst, i_count, i_clear, o_expired.
module cordic_ci_watchdog #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_count,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_cnt <= '0;
    end else if (i_count && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // r_cnt holds the number of WAIT cycles already completed
  assign o_expired = i_count && (r_cnt == LAST);

endmodule

// File: rtl/cordic_ci_ctrl.sv
// Custom-instruction front end: launches the delay stage, captures dp_out on
// its done and returns it with a one-cycle done. Optional watchdog:
// define CORDIC_CTRL_TIMEOUT_EN.
// Ports: clk, rst, clk_en, start, dataa, result, done, busy, dp_in,
// dp_in_valid, dp_out, dly_rst, dly_max, dly_done.
module cordic_ci_ctrl
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W        = CORDIC_DATA_W,
  parameter int unsigned COUNTER_WIDTH = 10,
  parameter int unsigned DLY_MAX       = 8,
  parameter int unsigned TIMEOUT       = 1023,
  parameter logic [DATA_W-1:0] ERR_VALUE = DATA_W'(CORDIC_ERR_VALUE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic                     start,
  input  logic [DATA_W-1:0]        dataa,
  output logic [DATA_W-1:0]        result,
  output logic                     done,
  output logic                     busy,
  output logic [DATA_W-1:0]        dp_in,
  output logic                     dp_in_valid,
  input  logic [DATA_W-1:0]        dp_out,
  output logic                     dly_rst,
  output logic [COUNTER_WIDTH-1:0] dly_max,
  input  logic                     dly_done
);

  cordic_state_e     r_state;
  logic [DATA_W-1:0] r_dp_in;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_dly_rst;
  logic              r_dp_in_valid;
  logic              r_pending;
  logic              w_timeout;
  logic              w_in_wait;

  if (DLY_MAX >= (2 ** COUNTER_WIDTH) || TIMEOUT < 1) begin : g_bad_cfg
    $error("cordic_ci_ctrl: DLY_MAX or TIMEOUT out of range");
  end

  assign w_in_wait = (r_state == ST_WAIT);

`ifdef CORDIC_CTRL_TIMEOUT_EN
  cordic_ci_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_count  (clk_en && w_in_wait),
    .i_clear  (!w_in_wait),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_dp_in       <= '0;
      r_result      <= '0;
      r_done        <= 1'b0;
      r_dly_rst     <= 1'b0;
      r_dp_in_valid <= 1'b0;
      r_pending     <= 1'b0;
    end else if (clk_en) begin
      r_done        <= 1'b0;
      r_dly_rst     <= 1'b0;
      r_dp_in_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dp_in       <= dataa;
            r_dly_rst     <= 1'b1;
            r_dp_in_valid <= 1'b1;
            r_state       <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          // result already captured while frozen
          if (r_pending) begin
            r_pending <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_RESP;
          end else if (dly_done) begin
            r_result <= dp_out;
            r_done   <= 1'b1;
            r_state  <= ST_RESP;
          end else if (w_timeout) begin
            r_result <= ERR_VALUE;
            r_done   <= 1'b1;
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end else if (w_in_wait && dly_done && !r_pending) begin
      // dly_done lasts only two cycles; grab dp_out even while frozen
      r_result  <= dp_out;
      r_pending <= 1'b1;
    end
  end

  assign result      = r_result;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign dp_in       = r_dp_in;
  assign dp_in_valid = r_dp_in_valid;
  assign dly_rst     = r_dly_rst;
  assign dly_max     = COUNTER_WIDTH'(DLY_MAX);

endmodule

// File: tb/tb_cordic_ci_ctrl.sv
// Directed bench for cordic_ci_ctrl with a behavioural delay stage and a
// dataa+1 datapath model.
module tb_cordic_ci_ctrl;

  localparam int M = 8;
`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;
  logic        busy;
  logic [31:0] dp_in;
  logic        dp_in_valid;
  logic [31:0] dp_out;
  logic        dly_rst;
  logic [9:0]  dly_max;
  logic        dly_done;
  logic        dly_kill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_ci_ctrl #(
    .DATA_W(32),
    .COUNTER_WIDTH(10),
    .DLY_MAX(M),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .start(start),
    .dataa(dataa),
    .result(result),
    .done(done),
    .busy(busy),
    .dp_in(dp_in),
    .dp_in_valid(dp_in_valid),
    .dp_out(dp_out),
    .dly_rst(dly_rst),
    .dly_max(dly_max),
    .dly_done(dly_done)
  );

  // delay stage: done high for two cycles, M+2 cycles after the rst pulse
  int dcnt = -1;
  always @(posedge clk) begin
    if (dly_rst) dcnt <= 0;
    else if (dcnt >= 0 && dcnt < M + 3) dcnt <= dcnt + 1;
    else dcnt <= -1;
  end
  assign dly_done = !dly_kill && (dcnt == M + 1 || dcnt == M + 2);
  assign dp_out = dp_in + 32'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // returns in the done cycle (or after 60 cycles with lat=0)
  task automatic do_req(input logic [31:0] a, output int lat,
                        output logic [31:0] res, output int rfirst,
                        output int rcnt);
    lat = 0; rfirst = 0; rcnt = 0; res = 'x;
    dataa = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (dly_rst) begin
        rcnt++;
        if (rfirst == 0) rfirst = n;
      end
      if (done) begin
        lat = n;
        res = result;
        break;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] r;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int lat, rf, rc, first, ndone;
    logic [31:0] res;

    tbl[0] = '{32'h0000_4000, 32'h0000_4001};
    tbl[1] = '{32'h0000_0000, 32'h0000_0001};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
    tbl[3] = '{32'h1234_5678, 32'h1234_5679};

    rst = 1'b1; clk_en = 1'b1; start = 1'b0; dataa = '0; dly_kill = 1'b0;
    repeat (3) tick();
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dp_in", dp_in, 32'd0);
    chk("rst_dpv", {31'd0, dp_in_valid}, 32'd0);
    chk("rst_dlyrst", {31'd0, dly_rst}, 32'd0);
    chk("dly_max", {22'd0, dly_max}, 32'd8);
    rst = 1'b0;
    tick();

    // back-to-back: each start lands in the cycle after the previous done
    for (int i = 0; i < 4; i++) begin
      do_req(tbl[i].a, lat, res, rf, rc);
      chk($sformatf("v%0d_lat", i), lat, 32'd12);
      chk($sformatf("v%0d_res", i), res, tbl[i].r);
      chk($sformatf("v%0d_rst_at", i), rf, 32'd1);
      chk($sformatf("v%0d_rst_n", i), rc, 32'd1);
      tick();
      chk($sformatf("v%0d_done_lo", i), {31'd0, done}, 32'd0);
    end

    // start pulsed during WAIT is ignored
    first = 0; ndone = 0;
    dataa = 32'hAAAA_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
      if (n == 4) begin start = 1'b1; dataa = 32'h0000_0055; end
      if (n == 5) start = 1'b0;
      tick();
    end
    chk("wstart_lat", first, 32'd12);
    chk("wstart_ndone", ndone, 32'd1);
    chk("wstart_res", result, 32'hAAAA_0001);
    chk("wstart_dp_in", dp_in, 32'hAAAA_0000);

    // clk_en low for cycles T+10..T+14: capture at T+11, done at T+16
    first = 0; ndone = 0;
    dataa = 32'h0BAD_0000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (done) begin
        ndone++;
        if (first == 0) first = n;
      end
      if (n == 12) begin
        chk("frz_res", result, 32'h0BAD_0001);
        chk("frz_busy", {31'd0, busy}, 32'd1);
      end
      if (n == 10) clk_en = 1'b0;
      if (n == 15) clk_en = 1'b1;
      tick();
    end
    chk("frz_lat", first, 32'd16);
    chk("frz_ndone", ndone, 32'd1);

    // reset mid-operation; stale dly_done at T+11 must be ignored
    ndone = 0; first = 0;
    dataa = 32'h0000_1357; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      if (done) ndone++;
      if (n >= 7 && busy) first++;
      if (n == 6) rst = 1'b1;
      if (n == 7) rst = 1'b0;
      tick();
    end
    chk("abort_ndone", ndone, 32'd0);
    chk("abort_busy_cyc", first, 32'd0);
    chk("abort_result", result, 32'd0);
    chk("abort_dp_in", dp_in, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dpv", {31'd0, dp_in_valid}, 32'd0);
    chk("abort_dlyrst", {31'd0, dly_rst}, 32'd0);

`ifdef CORDIC_CTRL_TIMEOUT_EN
    dly_kill = 1'b1;
    do_req(32'h0000_0777, lat, res, rf, rc);
    chk("to_lat", lat, 32'd22);
    chk("to_res", res, 32'hDEAD_BEEF);
    dly_kill = 1'b0;
    tick();
`endif

    // one more normal request after all corner cases
    do_req(32'h0000_4000, lat, res, rf, rc);
    chk("post_lat", lat, 32'd12);
    chk("post_res", res, 32'h0000_4001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
